bitscan_sequencer: RTL

//   Accepts a WIDTH-bit mask (pending-interrupt set, register write mask, etc.).

---
 rtl/bitscan_sequencer.sv | 113 +++++++++++
 1 files changed

// File: rtl/bitscan_sequencer.sv
// Emits set-bit indices of a mask, lowest first, one per valid/ready beat.
// Optional BITSCAN_ABORT_EN adds an abort input that drops the rest of a job.
module bitscan_sequencer #(
  parameter int WIDTH = 32,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_mask,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             done,
  output logic             busy
`ifdef BITSCAN_ABORT_EN
  ,
  input  logic             abort
`endif
);

  typedef enum logic {
    IDLE,
    SCAN
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_rem_clr;
  logic             r_done;
  logic             w_done_nxt;
  logic [IDX_W-1:0] w_ctz;
  logic             w_last;
  logic             w_scan;
  logic             w_xfer;
  logic             w_abort;

`ifdef BITSCAN_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  // Descending scan so the lowest set bit is the final assignment.
  always_comb begin
    w_ctz = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (r_rem[i]) w_ctz = IDX_W'(i);
    end
  end

  assign w_rem_clr = r_rem & (r_rem - WIDTH'(1));
  assign w_last    = (w_rem_clr == '0);
  assign w_scan    = (r_state == SCAN);
  assign w_xfer    = w_scan & out_ready;

  assign in_ready  = ~w_scan;
  assign busy      = w_scan;
  assign out_valid = w_scan;
  assign out_idx   = w_ctz;
  assign out_last  = w_scan & w_last;
  assign done      = r_done;

  always_comb begin
    w_state_nxt = r_state;
    w_rem_nxt   = r_rem;
    w_done_nxt  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (in_valid) begin
          if (in_mask != '0) begin
            w_rem_nxt   = in_mask;
            w_state_nxt = SCAN;
          end else begin
            w_done_nxt = 1'b1;
          end
        end
      end
      SCAN: begin
        if (w_abort) begin
          w_rem_nxt   = '0;
          w_state_nxt = IDLE;
        end else if (w_xfer) begin
          w_rem_nxt = w_rem_clr;
          if (w_last) begin
            w_state_nxt = IDLE;
            w_done_nxt  = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_rem   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_rem   <= w_rem_nxt;
      r_done  <= w_done_nxt;
    end
  end

endmodule
